// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with internal beq/bne resolution and memory-wait timeout
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter bit ENABLE_BNE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, R_EXEC = 4'd7, R_WB = 4'd8, BRANCH = 4'd9,
    JUMP = 4'd10, ADDI_EXEC = 4'd11, ADDI_WB = 4'd12
  } state_t;
  localparam int CW = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
    OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic is_bne, waiting, timeout;
  assign waiting = (cur == FETCH || cur == MEM_READ || cur == MEM_WRITE) && !mem_ready;
  assign timeout = (MEM_WAIT_MAX > 0) && waiting && (cnt == CW'(MEM_WAIT_MAX - 1));
  assign state = cur;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= IDLE;
      cnt <= '0;
      is_bne <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= (waiting && nxt == cur) ? cnt + 1'b1 : '0;
      if (cur == DECODE) is_bne <= ENABLE_BNE && (opcode == OP_BNE);
    end
  always_comb begin
    nxt = FETCH;
    pc_en = 1'b0;
    pc_source = 2'b00;
    ir_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    iord = 1'b0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_timeout = timeout;
    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_en = mem_ready;
        nxt = mem_ready ? DECODE : timeout ? IDLE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_R:         nxt = R_EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_BNE: begin
            nxt = ENABLE_BNE ? BRANCH : FETCH;
            illegal_op = !ENABLE_BNE;
          end
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDI_EXEC;
          default:      illegal_op = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord = 1'b1;
        nxt = mem_ready ? MEM_WB : timeout ? IDLE : MEM_READ;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = !timeout;
        iord = 1'b1;
        instr_done = mem_ready;
        nxt = mem_ready ? FETCH : timeout ? IDLE : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        nxt = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_source = 2'b01;
        pc_en = is_bne ? !zero : zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_en = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: per-instruction expected-trace scoreboard with random opcodes, waits and zero flag
module tb_mips_multicycle_ctrl;
  localparam int WMAX = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
    BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic instr_done, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  mips_multicycle_ctrl #(.MEM_WAIT_MAX(WMAX), .ENABLE_BNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] st;
    logic pc_en;
    logic [1:0] pc_source;
    logic ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic instr_done, illegal_op, mem_timeout;
  } out_t;
  typedef struct packed {
    logic mr;
    logic z;
    logic [5:0] op;
    out_t e;
  } cyc_t;
  cyc_t q[$];
  int checks = 0, failures = 0, ncyc = 0;
  int fw_fetch = -1, fw_mem = -1, fz = -1;
  out_t obs;
  function automatic out_t blank(input logic [3:0] st);
    blank = '0;
    blank.st = st;
  endfunction
  function automatic void push(input out_t e, input logic [5:0] op, input int mr, input int z);
    cyc_t c;
    c.e = e;
    c.op = op;
    c.mr = (mr < 0) ? 1'($urandom) : (mr != 0);
    c.z = (z < 0) ? 1'($urandom) : (z != 0);
    q.push_back(c);
  endfunction
  function automatic int pick_wait(input int forced);
    if (forced >= 0) return forced;
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 5));
  endfunction
  // A memory access waits w cycles; reaching the limit aborts to IDLE. Returns 1 on abort.
  function automatic bit mem_phase(input out_t base, input logic [5:0] op, input int forced,
                                   input bit is_fetch, input bit is_write);
    int w;
    out_t e;
    w = pick_wait(forced);
    for (int k = 0; k < WMAX; k++) begin
      e = base;
      if (k == w) begin
        if (is_fetch) begin
          e.ir_write = 1'b1;
          e.pc_en = 1'b1;
        end
        if (is_write) e.instr_done = 1'b1;
        push(e, op, 1, -1);
        return 1'b0;
      end
      if (k == WMAX - 1) begin
        e.mem_timeout = 1'b1;
        e.mem_write = 1'b0;
        push(e, op, 0, -1);
        push(blank(4'd0), 6'($urandom), -1, -1);
        return 1'b1;
      end
      push(e, op, 0, -1);
    end
    return 1'b0;
  endfunction
  function automatic void build(input logic [5:0] op);
    out_t e;
    int zz;
    e = blank(4'd1);
    e.mem_read = 1'b1;
    e.alu_src_b = 2'b01;
    if (mem_phase(e, 6'($urandom), fw_fetch, 1'b1, 1'b0)) return;
    e = blank(4'd2);
    e.alu_src_b = 2'b11;
    e.illegal_op = !(op inside {LW, SW, RT, BEQ, BNE, JMP, ADDI});
    push(e, op, -1, -1);
    if (e.illegal_op) return;
    case (op)
      LW, SW: begin
        e = blank(4'd3);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        push(e, op, -1, -1);
        if (op == LW) begin
          e = blank(4'd4);
          e.mem_read = 1'b1;
          e.iord = 1'b1;
          if (mem_phase(e, op, fw_mem, 1'b0, 1'b0)) return;
          e = blank(4'd5);
          e.reg_write = 1'b1;
          e.mem_to_reg = 1'b1;
          e.instr_done = 1'b1;
          push(e, op, -1, -1);
        end else begin
          e = blank(4'd6);
          e.mem_write = 1'b1;
          e.iord = 1'b1;
          void'(mem_phase(e, op, fw_mem, 1'b0, 1'b1));
        end
      end
      RT: begin
        e = blank(4'd7);
        e.alu_src_a = 1'b1;
        e.alu_op = 2'b10;
        push(e, op, -1, -1);
        e = blank(4'd8);
        e.reg_write = 1'b1;
        e.reg_dst = 1'b1;
        e.instr_done = 1'b1;
        push(e, op, -1, -1);
      end
      BEQ, BNE: begin
        zz = (fz >= 0) ? fz : int'($urandom_range(0, 1));
        e = blank(4'd9);
        e.alu_src_a = 1'b1;
        e.alu_op = 2'b01;
        e.pc_source = 2'b01;
        e.pc_en = (op == BNE) ? (zz == 0) : (zz == 1);
        e.instr_done = 1'b1;
        push(e, op, -1, zz);
      end
      JMP: begin
        e = blank(4'd10);
        e.pc_source = 2'b10;
        e.pc_en = 1'b1;
        e.instr_done = 1'b1;
        push(e, op, -1, -1);
      end
      default: begin
        e = blank(4'd11);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        push(e, op, -1, -1);
        e = blank(4'd12);
        e.reg_write = 1'b1;
        e.instr_done = 1'b1;
        push(e, op, -1, -1);
      end
    endcase
  endfunction
  task automatic check_now(input out_t exp, input string tag);
    obs = {state, pc_en, pc_source, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op, mem_timeout};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, ncyc, obs, exp);
    end
  endtask
  task automatic run_q(input int stop_st);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.mr;
      zero = c.z;
      opcode = c.op;
      #1;
      check_now(c.e, "trace");
      ncyc++;
      if (int'(c.e.st) == stop_st) q.delete();
    end
  endtask
  logic [5:0] ops[8];
  initial begin
    ops = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, 6'h3f};
    repeat (2) @(posedge clk);
    #1;
    check_now('0, "reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(blank(4'd0), 6'($urandom), -1, -1);
    fw_fetch = 0;
    fw_mem = 0;
    build(LW);
    fz = 1;
    build(BEQ);
    build(BNE);
    fz = 0;
    build(BNE);
    build(BEQ);
    fz = -1;
    fw_fetch = 3;
    build(RT);
    fw_fetch = 0;
    fw_mem = 99;
    build(SW);
    fw_mem = 99;
    build(LW);
    fw_mem = 0;
    build(6'h3f);
    build(JMP);
    build(ADDI);
    run_q(-1);
    fw_fetch = -1;
    fw_mem = -1;
    for (int i = 0; i < 300; i++) begin
      ops[7] = 6'($urandom);
      build(ops[$urandom_range(0, 7)]);
    end
    run_q(-1);
    fw_fetch = 0;
    fw_mem = 99;
    build(SW);
    run_q(6);
    rst_n = 1'b0;
    #1;
    check_now('0, "async_reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(blank(4'd0), 6'($urandom), -1, -1);
    fw_mem = 0;
    build(JMP);
    run_q(-1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
